// File: rtl/idct_pkg.sv
// idct_pkg: shared constants and types for the pipelined 8x8 Chen-Wang IDCT
package idct_pkg;
    localparam int W1 = 2841;
    localparam int W2 = 2676;
    localparam int W3 = 2408;
    localparam int W5 = 1609;
    localparam int W6 = 1108;
    localparam int W7 = 565;
    localparam int C181 = 181;
    localparam int LATENCY = 29;

    typedef logic signed [15:0] coef_t;
    typedef logic signed [31:0] word_t;
    typedef enum logic {ROW, COL} pass_t;

    function automatic word_t sx(input coef_t v);
        return word_t'(v);
    endfunction
endpackage

// File: rtl/idct_1d_pipe.sv
// idct_1d_pipe: 8-point Chen-Wang IDCT with 13 register stages, row or column scaling
//   clk, rst : clock, async active-high reset
//   b        : 8 signed 16-bit inputs (b[0] = element 0)
//   y        : 8 signed results, 16-bit (ROW, truncated) or 32-bit (COL, pre-clip)
module idct_1d_pipe
    import idct_pkg::*;
#(
    parameter pass_t MODE = ROW,
    localparam int OW = (MODE == ROW) ? 16 : 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0][15:0]   b,
    output logic [7:0][OW-1:0] y
);
    localparam int SH0 = (MODE == ROW) ? 11 : 8;
    localparam int RD0 = (MODE == ROW) ? 128 : 8192;
    localparam int RDW = (MODE == ROW) ? 0 : 4;
    localparam int SHW = (MODE == ROW) ? 0 : 3;
    localparam int SHF = (MODE == ROW) ? 8 : 14;

    coef_t r0 [8];
    word_t a [11];
    word_t p [3][9];
    word_t pa [3][2];
    // c: x0,x8,x2,x3,x4,x5,x6,x7 after the W rotations and the first butterfly
    word_t c [8];
    // d: x1,x4,x6,x5,x7,x8,x3,x0 after the second butterfly
    word_t d [8];
    word_t e [2];
    word_t m [3][2];
    // dl: x1,x6,x7,x8,x3,x0 carried alongside the 181 rotation
    word_t dl [5][6];
    word_t f [2];
    word_t yv [8];

    always_comb begin
        yv[0] = (dl[4][2] + dl[4][0]) >>> SHF;
        yv[1] = (dl[4][4] + f[0]) >>> SHF;
        yv[2] = (dl[4][5] + f[1]) >>> SHF;
        yv[3] = (dl[4][3] + dl[4][1]) >>> SHF;
        yv[4] = (dl[4][3] - dl[4][1]) >>> SHF;
        yv[5] = (dl[4][5] - f[1]) >>> SHF;
        yv[6] = (dl[4][4] - f[0]) >>> SHF;
        yv[7] = (dl[4][2] - dl[4][0]) >>> SHF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0 <= '{default: '0};
            a  <= '{default: '0};
            p  <= '{default: '0};
            pa <= '{default: '0};
            c  <= '{default: '0};
            d  <= '{default: '0};
            e  <= '{default: '0};
            m  <= '{default: '0};
            dl <= '{default: '0};
            f  <= '{default: '0};
            y  <= '0;
        end else begin
            for (int k = 0; k < 8; k++) r0[k] <= coef_t'(b[k]);
            a[0]  <= (sx(r0[0]) <<< SH0) + RD0;
            a[1]  <= sx(r0[4]) <<< SH0;
            a[2]  <= sx(r0[1]) + sx(r0[7]);
            a[3]  <= sx(r0[5]) + sx(r0[3]);
            a[4]  <= sx(r0[2]) + sx(r0[6]);
            a[5]  <= sx(r0[1]);
            a[6]  <= sx(r0[7]);
            a[7]  <= sx(r0[5]);
            a[8]  <= sx(r0[3]);
            a[9]  <= sx(r0[6]);
            a[10] <= sx(r0[2]);
            p[0][0] <= W7 * a[2];
            p[0][1] <= (W1 - W7) * a[5];
            p[0][2] <= (W1 + W7) * a[6];
            p[0][3] <= W3 * a[3];
            p[0][4] <= (W3 - W5) * a[7];
            p[0][5] <= (W3 + W5) * a[8];
            p[0][6] <= W6 * a[4];
            p[0][7] <= (W2 + W6) * a[9];
            p[0][8] <= (W2 - W6) * a[10];
            pa[0][0] <= a[0];
            pa[0][1] <= a[1];
            for (int k = 1; k < 3; k++) begin
                p[k]  <= p[k-1];
                pa[k] <= pa[k-1];
                m[k]  <= m[k-1];
            end
            c[0] <= pa[2][0] - pa[2][1];
            c[1] <= pa[2][0] + pa[2][1];
            c[2] <= (p[2][6] + RDW - p[2][7]) >>> SHW;
            c[3] <= (p[2][6] + RDW + p[2][8]) >>> SHW;
            c[4] <= (p[2][0] + RDW + p[2][1]) >>> SHW;
            c[5] <= (p[2][0] + RDW - p[2][2]) >>> SHW;
            c[6] <= (p[2][3] + RDW - p[2][4]) >>> SHW;
            c[7] <= (p[2][3] + RDW - p[2][5]) >>> SHW;
            d[0] <= c[4] + c[6];
            d[1] <= c[4] - c[6];
            d[2] <= c[5] + c[7];
            d[3] <= c[5] - c[7];
            d[4] <= c[1] + c[3];
            d[5] <= c[1] - c[3];
            d[6] <= c[0] + c[2];
            d[7] <= c[0] - c[2];
            e[0] <= d[1] + d[3];
            e[1] <= d[1] - d[3];
            dl[0] <= '{d[0], d[2], d[4], d[5], d[6], d[7]};
            for (int k = 1; k < 5; k++) dl[k] <= dl[k-1];
            m[0][0] <= C181 * e[0];
            m[0][1] <= C181 * e[1];
            f[0] <= (m[2][0] + 128) >>> 8;
            f[1] <= (m[2][1] + 128) >>> 8;
            for (int k = 0; k < 8; k++) y[k] <= yv[k][OW-1:0];
        end
    end
endmodule

// File: rtl/idct_8x8_pipe.sv
// idct_8x8_pipe: streaming 8x8 integer IDCT, one block per clock, 29-clock latency
//   clk, rst      : clock, async active-high reset
//   x0..x63       : signed coefficients, row-major
//   out0..out63   : signed clipped residuals [-256,255], row-major
module idct_8x8_pipe
    import idct_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] x0, x1, x2, x3, x4, x5, x6, x7,
    input  logic signed [15:0] x8, x9, x10, x11, x12, x13, x14, x15,
    input  logic signed [15:0] x16, x17, x18, x19, x20, x21, x22, x23,
    input  logic signed [15:0] x24, x25, x26, x27, x28, x29, x30, x31,
    input  logic signed [15:0] x32, x33, x34, x35, x36, x37, x38, x39,
    input  logic signed [15:0] x40, x41, x42, x43, x44, x45, x46, x47,
    input  logic signed [15:0] x48, x49, x50, x51, x52, x53, x54, x55,
    input  logic signed [15:0] x56, x57, x58, x59, x60, x61, x62, x63,
    output logic signed [15:0] out0, out1, out2, out3, out4, out5, out6, out7,
    output logic signed [15:0] out8, out9, out10, out11, out12, out13, out14, out15,
    output logic signed [15:0] out16, out17, out18, out19, out20, out21, out22, out23,
    output logic signed [15:0] out24, out25, out26, out27, out28, out29, out30, out31,
    output logic signed [15:0] out32, out33, out34, out35, out36, out37, out38, out39,
    output logic signed [15:0] out40, out41, out42, out43, out44, out45, out46, out47,
    output logic signed [15:0] out48, out49, out50, out51, out52, out53, out54, out55,
    output logic signed [15:0] out56, out57, out58, out59, out60, out61, out62, out63
);
    logic [63:0][15:0]     xv, ov;
    logic [7:0][7:0][15:0] ry, cb;
    logic [7:0][7:0][31:0] cy;
    word_t                 v1 [64];
    logic [63:0]           hi, lo;
    coef_t                 s2 [64];

    assign xv = {x63, x62, x61, x60, x59, x58, x57, x56, x55, x54, x53, x52, x51, x50, x49, x48,
                 x47, x46, x45, x44, x43, x42, x41, x40, x39, x38, x37, x36, x35, x34, x33, x32,
                 x31, x30, x29, x28, x27, x26, x25, x24, x23, x22, x21, x20, x19, x18, x17, x16,
                 x15, x14, x13, x12, x11, x10, x9, x8, x7, x6, x5, x4, x3, x2, x1, x0};
    assign {out63, out62, out61, out60, out59, out58, out57, out56,
            out55, out54, out53, out52, out51, out50, out49, out48,
            out47, out46, out45, out44, out43, out42, out41, out40,
            out39, out38, out37, out36, out35, out34, out33, out32,
            out31, out30, out29, out28, out27, out26, out25, out24,
            out23, out22, out21, out20, out19, out18, out17, out16,
            out15, out14, out13, out12, out11, out10, out9, out8,
            out7, out6, out5, out4, out3, out2, out1, out0} = ov;

    // transpose: column c takes element c of every row result
    always_comb begin
        cb = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cb[c][r] = ry[r][c];
    end

    for (genvar i = 0; i < 8; i++) begin : g_1d
        idct_1d_pipe #(.MODE(ROW)) u_row (.clk(clk), .rst(rst), .b(xv[8*i +: 8]), .y(ry[i]));
        idct_1d_pipe #(.MODE(COL)) u_col (.clk(clk), .rst(rst), .b(cb[i]), .y(cy[i]));
    end

    // clip in three stages: compare, select, output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= '{default: '0};
            hi <= '0;
            lo <= '0;
            s2 <= '{default: '0};
            ov <= '0;
        end else begin
            for (int k = 0; k < 64; k++) begin
                v1[k] <= word_t'(cy[k % 8][k / 8]);
                hi[k] <= word_t'(cy[k % 8][k / 8]) > 255;
                lo[k] <= word_t'(cy[k % 8][k / 8]) < -256;
                s2[k] <= hi[k] ? 16'sd255 : lo[k] ? -16'sd256 : coef_t'(v1[k][15:0]);
                ov[k] <= s2[k];
            end
        end
    end
endmodule

// File: tb/tb_idct_8x8_pipe.sv
// tb_idct_8x8_pipe: directed table-driven bench for the pipelined 8x8 IDCT
module tb_idct_8x8_pipe;
    import idct_pkg::*;

    typedef struct {
        string              name;
        logic signed [15:0] xin [64];
        logic signed [15:0] exp [64];
        logic [63:0]        msk;
    } vec_t;

    logic clk = 0;
    logic rst = 0;
    logic signed [15:0] x [64];
    logic signed [15:0] out [64];
    int n_chk = 0;
    int n_fail = 0;
    vec_t tv [7];

    int mx [64] = '{-240, 8, -11, 47, 26, -6, 0, 5,
                    28, -6, 85, 44, -4, -25, 5, 16,
                    21, 8, 32, -16, -24, 0, 30, 12,
                    -2, 18, 0, -2, 0, 7, 0, -15,
                    7, 4, 15, -24, 0, 9, 8, -6,
                    4, 9, 0, -5, -6, 0, 0, 0,
                    -4, 0, -6, 0, 0, 10, -10, -8,
                    6, 0, 0, 0, 0, 0, 0, -8};
    int me [24] = '{21, -10, -26, -61, -43, -17, -22, -8,
                    5, -28, -47, -73, -11, -14, -24, -17,
                    -44, -47, -9, -12, -30, -33, -38, -37};

    always #5 clk = ~clk;

    idct_8x8_pipe dut (
        .clk(clk), .rst(rst),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .x8(x[8]), .x9(x[9]), .x10(x[10]), .x11(x[11]), .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
        .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]), .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]),
        .x24(x[24]), .x25(x[25]), .x26(x[26]), .x27(x[27]), .x28(x[28]), .x29(x[29]), .x30(x[30]), .x31(x[31]),
        .x32(x[32]), .x33(x[33]), .x34(x[34]), .x35(x[35]), .x36(x[36]), .x37(x[37]), .x38(x[38]), .x39(x[39]),
        .x40(x[40]), .x41(x[41]), .x42(x[42]), .x43(x[43]), .x44(x[44]), .x45(x[45]), .x46(x[46]), .x47(x[47]),
        .x48(x[48]), .x49(x[49]), .x50(x[50]), .x51(x[51]), .x52(x[52]), .x53(x[53]), .x54(x[54]), .x55(x[55]),
        .x56(x[56]), .x57(x[57]), .x58(x[58]), .x59(x[59]), .x60(x[60]), .x61(x[61]), .x62(x[62]), .x63(x[63]),
        .out0(out[0]), .out1(out[1]), .out2(out[2]), .out3(out[3]), .out4(out[4]), .out5(out[5]), .out6(out[6]), .out7(out[7]),
        .out8(out[8]), .out9(out[9]), .out10(out[10]), .out11(out[11]), .out12(out[12]), .out13(out[13]), .out14(out[14]), .out15(out[15]),
        .out16(out[16]), .out17(out[17]), .out18(out[18]), .out19(out[19]), .out20(out[20]), .out21(out[21]), .out22(out[22]), .out23(out[23]),
        .out24(out[24]), .out25(out[25]), .out26(out[26]), .out27(out[27]), .out28(out[28]), .out29(out[29]), .out30(out[30]), .out31(out[31]),
        .out32(out[32]), .out33(out[33]), .out34(out[34]), .out35(out[35]), .out36(out[36]), .out37(out[37]), .out38(out[38]), .out39(out[39]),
        .out40(out[40]), .out41(out[41]), .out42(out[42]), .out43(out[43]), .out44(out[44]), .out45(out[45]), .out46(out[46]), .out47(out[47]),
        .out48(out[48]), .out49(out[49]), .out50(out[50]), .out51(out[51]), .out52(out[52]), .out53(out[53]), .out54(out[54]), .out55(out[55]),
        .out56(out[56]), .out57(out[57]), .out58(out[58]), .out59(out[59]), .out60(out[60]), .out61(out[61]), .out62(out[62]), .out63(out[63])
    );

    function automatic vec_t dc(input string n, input int din, input int dout);
        vec_t v;
        v.name = n;
        v.msk = '1;
        for (int k = 0; k < 64; k++) begin
            v.xin[k] = '0;
            v.exp[k] = 16'(dout);
        end
        v.xin[0] = 16'(din);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input vec_t v);
        for (int k = 0; k < 64; k++) x[k] = v.xin[k];
    endtask

    task automatic check(input string n, input vec_t v);
        for (int k = 0; k < 64; k++) begin
            if (v.msk[k]) begin
                n_chk++;
                if (out[k] !== v.exp[k]) begin
                    n_fail++;
                    $display("FAIL %s out%0d got %0d want %0d", n, k, out[k], v.exp[k]);
                end
            end
        end
    endtask

    initial begin
        tv[0] = dc("zero", 0, 0);
        tv[1] = dc("dc_m240", -240, -30);
        tv[2] = dc("dc_2047_clip_hi", 2047, 255);
        tv[3] = dc("dc_m2048_clip_lo", -2048, -256);
        tv[4] = dc("dc_8_round", 8, 1);
        tv[5] = dc("dc_m8_round", -8, -1);
        tv[6].name = "mixed";
        tv[6].msk = '0;
        for (int k = 0; k < 64; k++) begin
            tv[6].xin[k] = 16'(mx[k]);
            tv[6].exp[k] = '0;
        end
        for (int j = 0; j < 16; j++) begin
            tv[6].exp[j] = 16'(me[j]);
            tv[6].msk[j] = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
            tv[6].exp[56+j] = 16'(me[16+j]);
            tv[6].msk[56+j] = 1'b1;
        end

        put(tv[1]);
        rst = 1;
        #1;
        check("reset_async_start", tv[0]);
        step();
        step();
        check("reset_held", tv[0]);
        rst = 0;

        for (int i = 0; i < 7; i++) begin
            put(tv[i]);
            repeat (LATENCY) step();
            check(tv[i].name, tv[i]);
        end

        put(tv[0]);
        repeat (LATENCY) step();
        put(tv[1]);
        step();
        put(tv[2]);
        step();
        put(tv[6]);
        step();
        put(tv[0]);
        repeat (LATENCY - 4) step();
        check("b2b_before", tv[0]);
        step();
        check("b2b_first", tv[1]);
        step();
        check("b2b_second", tv[2]);
        step();
        check("b2b_third", tv[6]);
        step();
        check("b2b_after", tv[0]);

        put(tv[1]);
        repeat (LATENCY + 2) step();
        check("pre_midreset", tv[1]);
        #3 rst = 1;
        #1;
        check("midreset_async", tv[0]);
        put(tv[0]);
        step();
        step();
        check("midreset_held", tv[0]);
        rst = 0;
        put(tv[2]);
        step();
        put(tv[0]);
        repeat (LATENCY - 2) step();
        check("post_reset_edge28", tv[0]);
        step();
        check("post_reset_edge29", tv[2]);
        step();
        check("post_reset_edge30", tv[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
